// File: rtl/uart_tx_report.sv
// Report-frame UART transmitter: shadows config-bus parameter writes and, on request,
// sends HEADER, a snapshot of every parameter byte and an 8-bit checksum, 8N1.
module uart_tx_report #(
  parameter int unsigned ADDR_MAX    = 5,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned BIT_CNT_MAX = 434,
  parameter logic [7:0]  HEADER      = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              en,
  input  logic              send,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W   = (BIT_CNT_MAX > 1) ? $clog2(BIT_CNT_MAX) : 1;
  localparam int unsigned N_BYTES = ADDR_MAX + 2;
  localparam int unsigned BYTE_W  = $clog2(N_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_shadow [ADDR_MAX];
  logic [DATA_W-1:0] r_buf    [ADDR_MAX];
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_bit_idx;
  logic [BYTE_W-1:0] r_byte_idx;
  logic [7:0]        r_shift;
  logic [7:0]        r_chk;
  logic              r_tx;
  logic              r_busy;
  logic              r_done;
  logic              r_pending;

  logic              w_bit_end;
  logic              w_last_byte;
  logic [7:0]        w_next_param;

  assign w_bit_end   = (r_cnt == CNT_W'(BIT_CNT_MAX - 1));
  assign w_last_byte = (r_byte_idx == BYTE_W'(N_BYTES - 1));

  // Parameter byte that follows the byte currently on the line (index = r_byte_idx)
  always_comb begin
    w_next_param = '0;
    for (int i = 0; i < ADDR_MAX; i++) begin
      if (r_byte_idx == BYTE_W'(i)) w_next_param = r_buf[i];
    end
  end

  // Shadow copy of the config bus; out-of-range addresses never match a slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ADDR_MAX; i++) r_shadow[i] <= '0;
    end else begin
      for (int i = 0; i < ADDR_MAX; i++) begin
        if (en && (addr == ADDR_W'(i))) r_shadow[i] <= data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      for (int i = 0; i < ADDR_MAX; i++) r_buf[i] <= '0;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_chk      <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != S_IDLE) && send) r_pending <= 1'b1;
      if (r_state != S_IDLE) r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (send || r_pending) begin
            for (int i = 0; i < ADDR_MAX; i++) r_buf[i] <= r_shadow[i];
            r_state    <= S_START;
            r_shift    <= HEADER;
            r_chk      <= HEADER;
            r_byte_idx <= '0;
            r_cnt      <= '0;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_pending  <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state   <= S_DATA;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end
        end
        S_STOP: begin
          // done covers exactly the final clock of the checksum stop bit
          if (w_last_byte && (r_cnt == CNT_W'(BIT_CNT_MAX - 2))) r_done <= 1'b1;
          if (w_bit_end) begin
            if (w_last_byte) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state    <= S_START;
              r_tx       <= 1'b0;
              r_byte_idx <= r_byte_idx + 1'b1;
              if (r_byte_idx == BYTE_W'(ADDR_MAX)) begin
                r_shift <= r_chk;
              end else begin
                r_shift <= w_next_param;
                r_chk   <= r_chk + w_next_param;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_uart_tx_report.sv
// Directed bench for uart_tx_report with BIT_CNT_MAX=4, ADDR_MAX=5: decodes frames off tx
// and compares bytes, framing, done/busy timing against hand-computed values.
module tb_uart_tx_report;

  localparam int unsigned BITC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] addr;
  logic [7:0] data;
  logic       en;
  logic       send;
  logic       tx;
  logic       busy;
  logic       done;

  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;

  uart_tx_report #(
    .ADDR_MAX(5), .ADDR_W(4), .DATA_W(8), .BIT_CNT_MAX(BITC), .HEADER(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .en(en), .send(send),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) n_done++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    addr = a; data = d; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  // Leaves us on the first clock of the start bit
  task automatic pulse_send(input string tag);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check_eq({tag, "_lat_tx"}, 32'(tx), 32'd0);
    check_eq({tag, "_lat_busy"}, 32'(busy), 32'd1);
  endtask

  // Decode 7 bytes starting at the first clock of a start bit; ends on the idle clock after done
  task automatic rx_frame(input string tag, input logic [55:0] exp);
    logic [7:0] b;
    int t;
    t = 0;
    while (tx !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (tx !== 1'b0) check_eq({tag, "_start_timeout"}, 32'(tx), 32'd0);
    for (int i = 0; i < 7; i++) begin
      check_eq($sformatf("%s_b%0d_start", tag, i), 32'(tx), 32'd0);
      for (int k = 0; k < 8; k++) begin
        repeat (BITC) @(negedge clk);
        b[k] = tx;
      end
      check_eq($sformatf("%s_b%0d", tag, i), 32'(b), 32'(exp[55-8*i -: 8]));
      repeat (BITC) @(negedge clk);
      check_eq($sformatf("%s_b%0d_stop", tag, i), 32'(tx), 32'd1);
      if (i < 6) repeat (BITC) @(negedge clk);
    end
    repeat (BITC - 1) @(negedge clk);
    check_eq({tag, "_done_hi"}, 32'({done, busy}), 32'b11);
    @(negedge clk);
    check_eq({tag, "_done_lo"}, 32'({tx, busy, done}), 32'b100);
  endtask

  initial begin
    int d0;
    rst = 1'b1; addr = '0; data = '0; en = 1'b0; send = 1'b0;
    cyc(3);
    check_eq("reset_outs", 32'({tx, busy, done}), 32'b100);
    rst = 1'b0;

    // Idle with no send
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      check_eq("idle", 32'({tx, busy, done}), 32'b100);
    end

    // Reset-state frame, then an out-of-range write must not change it
    pulse_send("rstframe");
    rx_frame("rstframe", 56'hA5_00_00_00_00_00_A5);
    wr(4'd7, 8'hFF);
    cyc(2);
    pulse_send("oor");
    rx_frame("oor", 56'hA5_00_00_00_00_00_A5);

    // Basic frame
    wr(4'd0, 8'h7F); wr(4'd1, 8'h1E); wr(4'd2, 8'h0A); wr(4'd3, 8'h01); wr(4'd4, 8'hC8);
    cyc(2);
    pulse_send("basic");
    rx_frame("basic", 56'hA5_7F_1E_0A_01_C8_15);

    // Write during byte 2 lands only in the next frame
    cyc(5);
    pulse_send("midwr");
    fork
      rx_frame("midwr", 56'hA5_7F_1E_0A_01_C8_15);
      begin cyc(85); wr(4'd1, 8'h55); end
    join
    cyc(3);
    pulse_send("midwr2");
    rx_frame("midwr2", 56'hA5_7F_55_0A_01_C8_4C);

    // Two sends during a frame -> exactly one follow-on frame after a 1-clk gap
    cyc(4);
    d0 = n_done;
    pulse_send("pend");
    fork
      rx_frame("pend_a", 56'hA5_7F_55_0A_01_C8_4C);
      begin
        cyc(9);  send = 1'b1; @(negedge clk); send = 1'b0;
        cyc(38); send = 1'b1; @(negedge clk); send = 1'b0;
      end
    join
    @(negedge clk);
    check_eq("pend_gap", 32'({tx, busy}), 32'b01);
    rx_frame("pend_b", 56'hA5_7F_55_0A_01_C8_4C);
    cyc(100);
    check_eq("pend_quiet", 32'(busy), 32'd0);
    check_eq("pend_done_cnt", 32'(n_done - d0), 32'd2);

    // Async reset during byte 3 abandons the frame and clears shadows
    pulse_send("rstmid");
    cyc(125);
    rst = 1'b1;
    #1;
    check_eq("rstmid_async", 32'({tx, busy, done}), 32'b100);
    cyc(2);
    rst = 1'b0;
    cyc(20);
    check_eq("rstmid_idle", 32'({tx, busy}), 32'b10);
    pulse_send("after_rst");
    rx_frame("after_rst", 56'hA5_00_00_00_00_00_A5);

    cyc(10);
    check_eq("total_done", 32'(n_done), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
